// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified instruction/data memory between the
// core memory port and a program loader/debug port.
//
// An IDLE/BUSY/DONE sequencer handles one access at a time. Each access holds
// the memory strobes for MEM_LAT cycles and then pulses the winner's ack.
// The core has fixed priority. The loader is forced through after
// STARVE_LIMIT consecutive contested core wins. ldr_lock shuts the core out.
//
// Optional feature: define ARB_PERF_CNT_EN to enable the core stall-cycle
// counter. Without it, perf_stall_cnt is tied to 0.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   core_req/addr/we/wdata, core_ack, core_stall   core memory port
//   ldr_req/addr/we/wdata, ldr_lock, ldr_ack       loader/debug port
//   rdata               registered read data, valid with either ack
//   mem_en/we/addr/wdata, mem_rdata                memory side
//   perf_stall_cnt      core stall-cycle count
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic              core_stall,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic              ldr_we,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_stall_cnt
);

    localparam int unsigned LAT_W    = 4;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                owner_ldr;

    logic core_elig;
    logic starve_full;
    logic contested;
    logic grant_ldr;
    logic grant_core;

    // Arbitration decision, used only while IDLE
    always_comb begin
        core_elig   = core_req & ~ldr_lock;
        starve_full = (starve_cnt == STARVE_W'(STARVE_LIMIT));
        contested   = core_req & ldr_req & ~ldr_lock;
        grant_ldr   = ldr_req & (~core_elig | starve_full);
        grant_core  = core_elig & ~grant_ldr;
    end

    // Access sequencer. mem_addr/mem_wdata double as the latched request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_ldr  <= 1'b0;
            core_ack   <= 1'b0;
            ldr_ack    <= 1'b0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            core_ack <= 1'b0;
            ldr_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ldr || grant_core) begin
                        owner_ldr <= grant_ldr;
                        mem_addr  <= grant_ldr ? ldr_addr  : core_addr;
                        mem_wdata <= grant_ldr ? ldr_wdata : core_wdata;
                        mem_we    <= grant_ldr ? ldr_we    : core_we;
                        mem_en    <= 1'b1;
                        lat_cnt   <= LAT_W'(MEM_LAT - 1);
                        state     <= BUSY;
                        if (grant_ldr) begin
                            starve_cnt <= '0;
                        end else if (contested && !starve_full) begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        // Read data is only valid in the last access cycle
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        core_ack <= ~owner_ldr;
                        ldr_ack  <= owner_ldr;
                        state    <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign core_stall = core_req & ~core_ack;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Free-running stall counter, wraps at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (core_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with MEM_LAT=3 and
// STARVE_LIMIT=4. Inputs are driven 1 time unit after the rising edge, and
// registered outputs are sampled at that same point.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned MEM_LAT      = 3;
    localparam int unsigned STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic              core_we;
    logic [DATA_W-1:0] core_wdata;
    logic              core_ack;
    logic              core_stall;
    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic              ldr_we;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_lock;
    logic              ldr_ack;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_addr(core_addr), .core_we(core_we),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_stall(core_stall),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_we(ldr_we),
        .ldr_wdata(ldr_wdata), .ldr_lock(ldr_lock), .ldr_ack(ldr_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Continuous invariants: acks exclusive, no write strobe without enable
    always @(negedge clk) begin
        if (rst) begin
            if (core_ack || ldr_ack) check_eq("ack_exclusive", 32'(core_ack & ldr_ack), 32'd0);
            if (mem_we) check_eq("we_needs_en", 32'(mem_en), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int n;
        int cyc;
        int last;
        int core_grants;
        logic [31:0] exp_perf;

        rst = 1'b0;
        core_req = 1'b0; core_addr = '0; core_we = 1'b0; core_wdata = '0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_we = 1'b0; ldr_wdata = '0;
        ldr_lock = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_core_ack", 32'(core_ack), 32'd0);
        check_eq("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_perf", perf_stall_cnt, 32'd0);

        // Loader write alone, core read arrives two cycles later
        rst = 1'b1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h40; ldr_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            next_cycle;
            if (i == 1) begin
                core_req = 1'b1; core_addr = 32'h10; core_we = 1'b0; core_wdata = 32'h55;
            end
            check_eq("lw_mem_en", 32'(mem_en), 32'd1);
            check_eq("lw_mem_we", 32'(mem_we), 32'd1);
            check_eq("lw_mem_addr", mem_addr, 32'h40);
            check_eq("lw_mem_wdata", mem_wdata, 32'h1234_5678);
            check_eq("lw_ldr_ack_early", 32'(ldr_ack), 32'd0);
            check_eq("lw_core_ack", 32'(core_ack), 32'd0);
        end
        next_cycle;
        check_eq("lw_ldr_ack", 32'(ldr_ack), 32'd1);
        check_eq("lw_core_ack_done", 32'(core_ack), 32'd0);
        check_eq("lw_mem_en_done", 32'(mem_en), 32'd0);
        check_eq("lw_rdata_held", rdata, 32'd0);
        check_eq("lw_core_stall", 32'(core_stall), 32'd1);
        next_cycle;
        ldr_req = 1'b0; ldr_we = 1'b0;
        check_eq("lw_ldr_ack_pulse", 32'(ldr_ack), 32'd0);
        check_eq("lw_mem_en_idle", 32'(mem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle;
            if (i == 2) mem_rdata = 32'hDEAD_BEEF;
            check_eq("cr_mem_en", 32'(mem_en), 32'd1);
            check_eq("cr_mem_we", 32'(mem_we), 32'd0);
            check_eq("cr_mem_addr", mem_addr, 32'h10);
            check_eq("cr_core_ack_early", 32'(core_ack), 32'd0);
        end
        next_cycle;
        mem_rdata = 32'h0BAD_F00D;
        check_eq("cr_core_ack", 32'(core_ack), 32'd1);
        check_eq("cr_rdata", rdata, 32'hDEAD_BEEF);
        check_eq("cr_ldr_ack", 32'(ldr_ack), 32'd0);
        check_eq("cr_core_stall", 32'(core_stall), 32'd0);
`ifdef ARB_PERF_CNT_EN
        exp_perf = 32'd7;
`else
        exp_perf = 32'd0;
`endif
        check_eq("perf_stall_cnt", perf_stall_cnt, exp_perf);
        next_cycle;
        core_req = 1'b0;
        check_eq("cr_core_ack_pulse", 32'(core_ack), 32'd0);
        check_eq("cr_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Both requesting continuously: four core wins, then the loader
        next_cycle;
        core_req = 1'b1; core_addr = 32'h20; core_we = 1'b0;
        ldr_req = 1'b1; ldr_addr = 32'h60; ldr_we = 1'b0;
        n = 0; cyc = 0; last = 0;
        while (n < 10 && cyc < 200) begin
            next_cycle;
            cyc++;
            if (core_ack || ldr_ack) begin
                check_eq("starve_seq", 32'(ldr_ack), 32'(exp_seq[n]));
                if (ldr_ack) check_eq("starve_clr", 32'(dut.starve_cnt), 32'd0);
                if (n > 0) check_eq("ack_period", 32'(cyc - last), 32'(MEM_LAT + 2));
                last = cyc;
                n++;
            end
        end
        check_eq("starve_count", 32'(n), 32'd10);
        next_cycle;
        core_req = 1'b0; ldr_req = 1'b0;

        // Lock raised while a core access is in flight
        next_cycle;
        core_req = 1'b1; core_addr = 32'h30; core_we = 1'b0;
        next_cycle;
        ldr_lock = 1'b1; ldr_req = 1'b1; ldr_addr = 32'h70; ldr_we = 1'b1; ldr_wdata = 32'hCAFE_0001;
        check_eq("lk_mem_addr", mem_addr, 32'h30);
        next_cycle;
        next_cycle;
        next_cycle;
        check_eq("lk_core_completes", 32'(core_ack), 32'd1);
        core_grants = 0;
        for (int t = 0; t < 3; t++) begin
            cyc = 0;
            while (!ldr_ack && cyc < 50) begin
                next_cycle;
                cyc++;
                if (core_ack) core_grants++;
            end
            check_eq("lk_ldr_ack", 32'(ldr_ack), 32'd1);
            next_cycle;
            ldr_req = 1'b0;
            for (int k = 0; k < 2; k++) begin
                next_cycle;
                check_eq("lk_core_stall", 32'(core_stall), 32'd1);
                check_eq("lk_no_grant", 32'(mem_en), 32'd0);
            end
            if (t < 2) ldr_req = 1'b1;
        end
        check_eq("lk_core_grants", 32'(core_grants), 32'd0);
        next_cycle;
        ldr_lock = 1'b0;
        next_cycle;
        check_eq("unlk_mem_en", 32'(mem_en), 32'd1);
        check_eq("unlk_mem_addr", mem_addr, 32'h30);
        next_cycle;
        next_cycle;
        next_cycle;
        check_eq("unlk_core_ack", 32'(core_ack), 32'd1);
        next_cycle;
        core_req = 1'b0;

        // Reset in the middle of a core write
        next_cycle;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'hA5A5_A5A5;
        next_cycle;
        check_eq("rb_mem_we", 32'(mem_we), 32'd1);
        check_eq("rb_mem_en", 32'(mem_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rb_async_en", 32'(mem_en), 32'd0);
        check_eq("rb_async_we", 32'(mem_we), 32'd0);
        check_eq("rb_no_ack", 32'(core_ack), 32'd0);
        next_cycle;
        check_eq("rb_still_idle", 32'(mem_en), 32'd0);
        check_eq("rb_no_ack_held", 32'(core_ack), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle;
        check_eq("rb_regrant_en", 32'(mem_en), 32'd1);
        check_eq("rb_regrant_we", 32'(mem_we), 32'd1);
        check_eq("rb_regrant_addr", mem_addr, 32'h80);
        check_eq("rb_regrant_wdata", mem_wdata, 32'hA5A5_A5A5);
        next_cycle;
        next_cycle;
        next_cycle;
        check_eq("rb_core_ack", 32'(core_ack), 32'd1);
        next_cycle;
        core_req = 1'b0; core_we = 1'b0;
        next_cycle;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
